// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback port and issue/reservation handshake.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic [NREAD-1:0]      rd_busy;
  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic [AW:0]           busy_count;

  // Decode/writeback side
  modport master (
    output ra, we, wa, wd, issue_valid, issue_rd,
    input  rd, rd_busy, issue_ready, busy_count
  );

  // Register file side
  modport slave (
    input  ra, we, wa, wd, issue_valid, issue_rd,
    output rd, rd_busy, issue_ready, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with x0 hardwired to zero, optional write-to-read
// bypass, and a per-register busy scoreboard reserved through an issue handshake.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 2 ** AW;

  logic [XLEN-1:0]       regs_q [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [AW:0]           busy_count_q, busy_count_d;

  logic                  wr_en;
  logic                  iss_ready;
  logic                  iss_acc;
  logic                  cnt_inc, cnt_dec;
  logic [NREAD*XLEN-1:0] rd_d;
  logic [NREAD-1:0]      rd_busy_d;

  assign wr_en     = bus.we && !rst && (bus.wa != '0);
  assign iss_ready = !rst && ((bus.issue_rd == '0) || !busy_q[bus.issue_rd] ||
                              (bus.we && (bus.wa == bus.issue_rd)));
  // Accepting x0 is a pure handshake; it never reserves anything.
  assign iss_acc   = bus.issue_valid && iss_ready && (bus.issue_rd != '0);

  // Next busy vector: write clears first, then an accepted issue re-sets (reservation wins).
  always_comb begin
    busy_d = busy_q;
    if (wr_en)   busy_d[bus.wa]       = 1'b0;
    if (iss_acc) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy counter tracks popcount incrementally; a clear+set on one register cancels out.
  always_comb begin
    cnt_inc = iss_acc && !busy_q[bus.issue_rd];
    cnt_dec = wr_en && busy_q[bus.wa] && !(iss_acc && (bus.issue_rd == bus.wa));
    busy_count_d = busy_count_q;
    if (cnt_inc && !cnt_dec)      busy_count_d = busy_count_q + 1'b1;
    else if (cnt_dec && !cnt_inc) busy_count_d = busy_count_q - 1'b1;
  end

  // Combinational read ports with optional same-cycle writeback bypass.
  always_comb begin
    logic [AW-1:0] a;
    rd_d      = '0;
    rd_busy_d = '0;
    a         = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      a = bus.ra[p*AW +: AW];
      if (a == '0) begin
        rd_d[p*XLEN +: XLEN] = '0;
        rd_busy_d[p]         = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (bus.wa == a)) begin
        rd_d[p*XLEN +: XLEN] = bus.wd;
        rd_busy_d[p]         = iss_acc && (bus.issue_rd == a);
      end else begin
        rd_d[p*XLEN +: XLEN] = regs_q[a];
        rd_busy_d[p]         = busy_q[a];
      end
    end
  end

  // Array, scoreboard and counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr_en) regs_q[bus.wa] <= bus.wd;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign bus.rd          = rd_d;
  assign bus.rd_busy     = rd_busy_d;
  assign bus.issue_ready = iss_ready;
  assign bus.busy_count  = busy_count_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb: one BYPASS=1 three-port instance
// and one BYPASS=0 two-port instance sharing clock and reset.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5), .NREAD(3)) ifa ();
  regfile_sb_if #(.XLEN(32), .AW(5), .NREAD(2)) ifb ();

  regfile_sb #(.XLEN(32), .AW(5), .NREAD(3), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  regfile_sb #(.XLEN(32), .AW(5), .NREAD(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  ra0;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] e_rd;
    logic        e_busy;
    logic        e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vt [16];

  task automatic idle_a();
    ifa.ra = '0; ifa.we = 1'b0; ifa.wa = '0; ifa.wd = '0;
    ifa.issue_valid = 1'b0; ifa.issue_rd = '0;
  endtask

  task automatic idle_b();
    ifb.ra = '0; ifb.we = 1'b0; ifb.wa = '0; ifb.wd = '0;
    ifb.issue_valid = 1'b0; ifb.issue_rd = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        ra0  we  wa    wd            iv  ird    e_rd          bsy  rdy  cnt
    vt[0]  = '{5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0,  32'h0,        1'b0, 1'b1, 6'd0};
    vt[1]  = '{5'd7, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0,  32'h1234_5678, 1'b0, 1'b1, 6'd0};
    vt[2]  = '{5'd7, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3,  32'h1234_5678, 1'b0, 1'b1, 6'd0};
    vt[3]  = '{5'd3, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3,  32'h0,         1'b1, 1'b0, 6'd1};
    vt[4]  = '{5'd3, 1'b1, 5'd3, 32'h55,        1'b0, 5'd3,  32'h55,        1'b0, 1'b1, 6'd1};
    vt[5]  = '{5'd3, 1'b0, 5'd0, 32'h0,         1'b0, 5'd9,  32'h55,        1'b0, 1'b1, 6'd0};
    vt[6]  = '{5'd9, 1'b0, 5'd0, 32'h0,         1'b1, 5'd9,  32'h0,         1'b0, 1'b1, 6'd0};
    vt[7]  = '{5'd9, 1'b1, 5'd9, 32'hA,         1'b1, 5'd9,  32'hA,         1'b1, 1'b1, 6'd1};
    vt[8]  = '{5'd9, 1'b0, 5'd0, 32'h0,         1'b0, 5'd9,  32'hA,         1'b1, 1'b0, 6'd1};
    vt[9]  = '{5'd4, 1'b1, 5'd4, 32'h0BAD,      1'b0, 5'd4,  32'h0BAD,      1'b0, 1'b1, 6'd1};
    vt[10] = '{5'd9, 1'b1, 5'd9, 32'h77,        1'b1, 5'd10, 32'h77,        1'b0, 1'b1, 6'd1};
    vt[11] = '{5'd10,1'b0, 5'd0, 32'h0,         1'b0, 5'd10, 32'h0,         1'b1, 1'b0, 6'd1};
    vt[12] = '{5'd4, 1'b1, 5'd10,32'h1,         1'b1, 5'd4,  32'h0BAD,      1'b0, 1'b1, 6'd1};
    vt[13] = '{5'd4, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0BAD,      1'b1, 1'b1, 6'd1};
    vt[14] = '{5'd10,1'b1, 5'd4, 32'h2,         1'b0, 5'd4,  32'h1,         1'b0, 1'b1, 6'd1};
    vt[15] = '{5'd4, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h2,         1'b0, 1'b1, 6'd0};

    idle_a();
    idle_b();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_count", 64'(ifa.busy_count), 64'd0);
    chk("reset_ready_in_rst", 64'(ifa.issue_ready), 64'd0);
    rst = 1'b0;
    next_cycle();

    // Table-driven sequence on the bypassing instance
    for (int i = 0; i < 16; i++) begin
      ifa.ra          = {5'd0, 5'd0, vt[i].ra0};
      ifa.we          = vt[i].we;
      ifa.wa          = vt[i].wa;
      ifa.wd          = vt[i].wd;
      ifa.issue_valid = vt[i].iv;
      ifa.issue_rd    = vt[i].ird;
      @(negedge clk);
      chk($sformatf("v%0d_rd0", i),    64'(ifa.rd[31:0]),      64'(vt[i].e_rd));
      chk($sformatf("v%0d_busy0", i),  64'(ifa.rd_busy[0]),    64'(vt[i].e_busy));
      chk($sformatf("v%0d_ready", i),  64'(ifa.issue_ready),   64'(vt[i].e_rdy));
      chk($sformatf("v%0d_count", i),  64'(ifa.busy_count),    64'(vt[i].e_cnt));
      next_cycle();
    end
    idle_a();

    // Multi-port: reserve x1, x2, x3 on consecutive cycles
    ifa.ra = {5'd3, 5'd2, 5'd1};
    for (int r = 1; r <= 3; r++) begin
      ifa.issue_valid = 1'b1;
      ifa.issue_rd    = 5'(r);
      next_cycle();
    end
    ifa.issue_valid = 1'b0;
    ifa.issue_rd    = '0;
    @(negedge clk);
    chk("mp_count3", 64'(ifa.busy_count), 64'd3);
    chk("mp_busy_all", 64'(ifa.rd_busy), 64'b111);
    next_cycle();
    ifa.we = 1'b1; ifa.wa = 5'd2; ifa.wd = 32'hC0DE;
    next_cycle();
    ifa.we = 1'b0;
    @(negedge clk);
    chk("mp_count2", 64'(ifa.busy_count), 64'd2);
    chk("mp_busy_x2_drop", 64'(ifa.rd_busy), 64'b101);
    chk("mp_rd_x2", 64'(ifa.rd[63:32]), 64'h0000C0DE);
    next_cycle();

    // Reset clears array and scoreboard
    ifa.we = 1'b1; ifa.wa = 5'd5; ifa.wd = 32'hDEAD_BEEF;
    next_cycle();
    ifa.ra = {5'd3, 5'd1, 5'd5};
    ifa.wa = 5'd6;
    ifa.issue_valid = 1'b1; ifa.issue_rd = 5'd7;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_x5", 64'(ifa.rd[31:0]), 64'hDEAD_BEEF);
    chk("rst_ready_low", 64'(ifa.issue_ready), 64'd0);
    next_cycle();
    rst = 1'b0;
    idle_a();
    ifa.ra = {5'd7, 5'd6, 5'd5};
    @(negedge clk);
    chk("rst_x5_zero", 64'(ifa.rd[31:0]), 64'd0);
    chk("rst_x6_zero", 64'(ifa.rd[63:32]), 64'd0);
    chk("rst_count_zero", 64'(ifa.busy_count), 64'd0);
    chk("rst_busy_zero", 64'(ifa.rd_busy), 64'd0);
    next_cycle();

    // Non-bypassing instance: reads return pre-edge array contents
    ifb.we = 1'b1; ifb.wa = 5'd7; ifb.wd = 32'h11;
    ifb.ra = {5'd0, 5'd7};
    next_cycle();
    ifb.wd = 32'h1234_5678;
    ifb.issue_valid = 1'b1; ifb.issue_rd = 5'd7;
    @(negedge clk);
    chk("nb_rd_old", 64'(ifb.rd[31:0]), 64'h11);
    chk("nb_busy_old", 64'(ifb.rd_busy[0]), 64'd0);
    chk("nb_ready", 64'(ifb.issue_ready), 64'd1);
    next_cycle();
    idle_b();
    ifb.ra = {5'd7, 5'd7};
    @(negedge clk);
    chk("nb_rd_new", 64'(ifb.rd[31:0]), 64'h1234_5678);
    chk("nb_rd1_new", 64'(ifb.rd[63:32]), 64'h1234_5678);
    chk("nb_busy_new", 64'(ifb.rd_busy), 64'b11);
    chk("nb_count", 64'(ifb.busy_count), 64'd1);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-cycle register file, for the pipelined RISC-V core. It provides N combinational read ports and one write port, with x0 hardwired to zero and an optional write-to-read bypass. It also holds a per-register busy scoreboard with an issue handshake, so decode can stall on RAW and WAW hazards. It sits between decode/issue (read and issue side) and writeback (write side).

Parameters:
XLEN, 32, data width of each register
AW, 5, register address width; register count NREG = 2**AW
NREAD, 2, number of read ports
BYPASS, 1, 1 = same-cycle writeback data and busy-clear are visible on reads; 0 = reads see only the array contents

Ports:
clk  input  1  clock, rising-edge sampled
rst  input  1  synchronous reset, active-high
ra  input  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]
rd  output  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rd_busy  output  NREAD  busy flag of the register addressed by port i
we  input  1  write enable (writeback)
wa  input  AW  write address
wd  input  XLEN  write data
issue_valid  input  1  decode requests to reserve destination issue_rd
issue_rd  input  AW  destination register to reserve
issue_ready  output  1  reservation accepted this cycle
busy_count  output  AW+1  number of registers currently busy

Behaviour:
- One clock domain (clk); rst is synchronous, active-high.
- Reset (rst=1 at a rising edge):
  - all NREG registers <= 0; all busy bits <= 0; busy_count <= 0.
  - While rst=1: issue_ready=0, and we/issue_valid have no effect.
- Reads are combinational and zero-latency.
  - ra_i==0: rd_i=0 and rd_busy_i=0.
  - Otherwise, if BYPASS=1 and we=1 and wa==ra_i: rd_i=wd and rd_busy_i=0, unless a same-cycle issue to that register is accepted (see below).
  - Otherwise: rd_i=array[ra_i] and rd_busy_i=busy[ra_i].
  - BYPASS=0: reads return the pre-edge array value and busy bit.
- Write: on a rising edge with we=1, rst=0 and wa!=0:
  - array[wa] <= wd; busy[wa] <= 0.
  - A write to a non-busy register is legal and leaves busy_count unchanged.
  - A write with wa==0 is ignored.
- Issue handshake:
  - issue_ready = !rst && (issue_rd==0 || !busy[issue_rd] || (we && wa==issue_rd)).
  - The handshake completes when issue_valid && issue_ready. On the next edge busy[issue_rd] <= 1; issue_rd==0 is accepted with no state change.
  - issue_ready does not depend on issue_valid; it is purely a function of issue_rd and state.
- Simultaneous write and accepted issue to the same register:
  - the data is written and busy ends at 1 (the new reservation wins).
  - busy_count is unchanged.
  - rd_busy on that address in that cycle shows 1; rd still shows bypassed wd when BYPASS=1.
- busy_count update per edge:
  - +1 if an issue sets a previously clear bit.
  - -1 if a write clears a previously set bit (not re-set by issue).
  - Both updates combine in the same edge.
  - busy_count always equals the popcount of the busy bits, and never exceeds NREG-1.
- Writes and issues on different registers in the same cycle are independent.

Test Plan:
- Reset clears: write 0xDEADBEEF to x5, assert rst 1 cycle -> rd(x5)=0, busy_count=0, issue_ready=0 during rst.
- x0 hardwired: we=1, wa=0, wd=0xFFFFFFFF; issue_rd=0 -> rd(x0)=0, rd_busy=0, busy_count stays 0, issue_ready=1.
- Bypass: BYPASS=1, ra0=7, we=1, wa=7, wd=0x12345678 in the same cycle -> rd0=0x12345678 combinationally. With BYPASS=0 -> rd0 shows the old value and the new value appears the next cycle.
- RAW/WAW stall: issue x3 accepted -> next cycle rd_busy(x3)=1, busy_count=1. A second issue to x3 gives issue_ready=0. Writeback x3=0x55 -> next cycle busy_count=0, rd(x3)=0x55.
- Same-cycle clear+set: x9 busy, we to x9 with wd=0xA and issue x9 accepted in the same cycle -> issue_ready=1, array[x9]=0xA, busy[x9]=1, busy_count unchanged.
- Multi-port/count: NREAD=3; issue x1, x2, x3 on consecutive cycles -> busy_count=3 and all three rd_busy=1. Write x2 -> busy_count=2, rd_busy for x2 only drops.
